// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared core widths, opcode encodings and the MMU request payload
package fcpu_pkg;
  localparam int RSV_ID_W = 4;
  localparam int INSTR_W = 8;
  localparam int DATA_W = 32;
  typedef enum logic [INSTR_W-1:0] {
    I_NOP    = 8'h00,
    I_LOAD   = 8'h01,
    I_STORE  = 8'h02,
    I_INPUT  = 8'h03,
    I_OUTPUT = 8'h04
  } opcode_e;
  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [INSTR_W-1:0]  opcode;
    logic [DATA_W-1:0]   address;
    logic [DATA_W-1:0]   data;
  } mmu_req_t;
endpackage

// File: rtl/mmu_request_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from last+1 with wrap
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);
  logic w_found;
  always_comb begin
    grant = '0;
    idx = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++)
      if (!w_found && req_vec[(int'(last) + k) % N_REQ]) begin
        grant[(int'(last) + k) % N_REQ] = 1'b1;
        idx = IDX_W'((int'(last) + k) % N_REQ);
        w_found = 1'b1;
      end
  end
endmodule

// File: rtl/mmu_request_arbiter.sv
// mmu_request_arbiter: round-robin arbiter feeding one registered request slot to the MMU
module mmu_request_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ-1:0][RSV_ID_W-1:0]     req_rsv_id,
  input  logic [N_REQ-1:0][INSTR_W-1:0]      req_opcode,
  input  logic [N_REQ-1:0][DATA_W-1:0]       req_address,
  input  logic [N_REQ-1:0][DATA_W-1:0]       req_data,
  output logic [N_REQ-1:0]                   req_ready,
  output logic                               mmu_valid,
  output logic [RSV_ID_W-1:0]                mmu_rsv_id,
  output logic [INSTR_W-1:0]                 mmu_opcode,
  output logic [DATA_W-1:0]                  mmu_address,
  output logic [DATA_W-1:0]                  mmu_data,
  input  logic                               mmu_ready,
  output logic [IDX_W-1:0]                   grant_idx,
  output logic [CNT_W-1:0]                   grant_cnt
);
  localparam logic [0:0] ARB_EMPTY = 1'b0;
  localparam logic [0:0] ARB_FULL = 1'b1;
  logic [0:0]       r_state;
  mmu_req_t         r_req;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_grant_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_slot_free;
  logic             w_take;
  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_vec(req_valid),
    .last(r_last),
    .grant(w_grant),
    .idx(w_idx)
  );
  // No grant while in reset: the slot cannot load, so an accept would be lost.
  assign w_slot_free = (r_state == ARB_EMPTY) || mmu_ready;
  assign req_ready = (!nrst && w_slot_free) ? w_grant : '0;
  assign w_take = !nrst && w_slot_free && |req_valid;
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= ARB_EMPTY;
      r_req <= '0;
      r_last <= IDX_W'(N_REQ - 1);
      r_grant_idx <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_state <= ARB_FULL;
      r_req <= '{rsv_id: req_rsv_id[w_idx], opcode: req_opcode[w_idx],
                 address: req_address[w_idx], data: req_data[w_idx]};
      r_last <= w_idx;
      r_grant_idx <= w_idx;
      r_cnt <= r_cnt + CNT_W'(!(&r_cnt));
    end else if (mmu_ready) begin
      r_state <= ARB_EMPTY;
    end
  end
  assign mmu_valid = (r_state == ARB_FULL);
  assign mmu_rsv_id = r_req.rsv_id;
  assign mmu_opcode = r_req.opcode;
  assign mmu_address = r_req.address;
  assign mmu_data = r_req.data;
  assign grant_idx = r_grant_idx;
  assign grant_cnt = r_cnt;
endmodule

// File: tb/tb_mmu_request_arbiter.sv
// tb_mmu_request_arbiter: directed scoreboard bench for the round-robin MMU arbiter
module tb_mmu_request_arbiter;
  import fcpu_pkg::*;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0][RSV_ID_W-1:0] req_rsv_id;
  logic [N-1:0][INSTR_W-1:0] req_opcode;
  logic [N-1:0][DATA_W-1:0] req_address;
  logic [N-1:0][DATA_W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic mmu_valid;
  logic [RSV_ID_W-1:0] mmu_rsv_id;
  logic [INSTR_W-1:0] mmu_opcode;
  logic [DATA_W-1:0] mmu_address;
  logic [DATA_W-1:0] mmu_data;
  logic mmu_ready = 1'b0;
  logic [IW-1:0] grant_idx;
  logic [CW-1:0] grant_cnt;
  mmu_request_arbiter #(.N_REQ(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_rsv_id(req_rsv_id),
    .req_opcode(req_opcode), .req_address(req_address), .req_data(req_data),
    .req_ready(req_ready), .mmu_valid(mmu_valid), .mmu_rsv_id(mmu_rsv_id),
    .mmu_opcode(mmu_opcode), .mmu_address(mmu_address), .mmu_data(mmu_data),
    .mmu_ready(mmu_ready), .grant_idx(grant_idx), .grant_cnt(grant_cnt)
  );
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  int accepts = 0;
  int grants = 0;
  mmu_req_t q[$];
  logic m_valid = 1'b0;
  int m_last = N - 1;
  int m_idx = 0;
  int m_cnt = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic renew(input int s);
    req_rsv_id[s] = req_rsv_id[s] + RSV_ID_W'(N);
    req_opcode[s] = INSTR_W'($urandom_range(0, 4));
    req_address[s] = $urandom;
    req_data[s] = $urandom;
  endtask
  task automatic cycle();
    int s;
    logic [N-1:0] g;
    mmu_req_t e;
    #1;
    s = (!nrst && (!m_valid || mmu_ready)) ? pick(req_valid, m_last) : -1;
    g = (s >= 0) ? N'(1) << s : '0;
    chk("req_ready", 64'(req_ready), 64'(g));
    if (m_valid) begin
      e = (q.size() > 0) ? q[0] : '0;
      chk("mmu_rsv_id", 64'(mmu_rsv_id), 64'(e.rsv_id));
      chk("mmu_opcode", 64'(mmu_opcode), 64'(e.opcode));
      chk("mmu_address", 64'(mmu_address), 64'(e.address));
      chk("mmu_data", 64'(mmu_data), 64'(e.data));
      chk("grant_idx", 64'(grant_idx), 64'(m_idx));
      if (mmu_ready && !nrst) begin
        if (q.size() > 0) void'(q.pop_front());
        accepts++;
      end
    end
    if (nrst) begin
      q.delete();
      m_valid = 1'b0;
      m_last = N - 1;
      m_idx = 0;
      m_cnt = 0;
    end else if (s >= 0) begin
      q.push_back('{rsv_id: req_rsv_id[s], opcode: req_opcode[s],
                    address: req_address[s], data: req_data[s]});
      m_valid = 1'b1;
      m_last = s;
      m_idx = s;
      m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      grants++;
    end else if (mmu_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("mmu_valid", 64'(mmu_valid), 64'(m_valid));
    chk("grant_cnt", 64'(grant_cnt), 64'(m_cnt));
    if (nrst) begin
      chk("rst_payload", 64'(mmu_address ^ mmu_data) | 64'(mmu_rsv_id) | 64'(mmu_opcode), 64'd0);
      chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    end
    if (s >= 0) renew(s);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      req_rsv_id[i] = RSV_ID_W'(i);
      req_opcode[i] = INSTR_W'(I_LOAD);
      req_address[i] = 32'h1000 * (i + 1);
      req_data[i] = 32'hA000_0000 + i;
    end
    nrst = 1'b1;
    req_valid = '1;
    mmu_ready = 1'b1;
    repeat (3) cycle();
    nrst = 1'b0;
    #1;
    chk("first_ready", 64'(req_ready), 64'b0001);
    repeat (5) cycle();
    chk("rr_cnt5", 64'(grant_cnt), 64'd5);
    req_valid = '0;
    cycle();
    req_valid = 4'b0100;
    mmu_ready = 1'b0;
    req_rsv_id[2] = 4'h6;
    req_opcode[2] = INSTR_W'(I_STORE);
    req_address[2] = 32'h0000_4000;
    req_data[2] = 32'hDEAD_BEEF;
    cycle();
    req_valid = '1;
    repeat (6) cycle();
    chk("bp_data", 64'(mmu_data), 64'hDEAD_BEEF);
    chk("bp_addr", 64'(mmu_address), 64'h4000);
    req_valid = '0;
    mmu_ready = 1'b1;
    cycle();
    chk("bp_once", 64'(accepts), 64'(6));
    req_valid = 4'b1000;
    cycle();
    req_valid = 4'b1010;
    cycle();
    chk("skip_idx1", 64'(grant_idx), 64'd1);
    cycle();
    chk("skip_idx3", 64'(grant_idx), 64'd3);
    req_valid = 4'b0001;
    req_opcode[0] = INSTR_W'(I_OUTPUT);
    cycle();
    chk("sim_valid", 64'(mmu_valid), 64'd1);
    chk("sim_idx", 64'(grant_idx), 64'd0);
    req_valid = '0;
    mmu_ready = 1'b0;
    cycle();
    nrst = 1'b1;
    cycle();
    chk("midrst_valid", 64'(mmu_valid), 64'd0);
    nrst = 1'b0;
    req_valid = '1;
    mmu_ready = 1'b1;
    repeat (20) cycle();
    chk("sat_cnt", 64'(grant_cnt), 64'd15);
    req_valid = '0;
    cycle();
    cycle();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
